sha256_padder: RTL
==================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter BSWAP, default 0; when 1, byte-reverses each accepted in_data word before storage.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, in_data/in_bytes/in_last are valid.
REQ-005 SHALL have port in_ready, output, 1, word accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_data, input, 32, message word, first byte in [31:24].
REQ-007 SHALL have port in_bytes, input, 3, valid bytes 0..4, MSB-aligned; below 4 only with in_last.
REQ-008 SHALL have port in_last, input, 1, final word of message.
REQ-009 SHALL have port blk_data, output, 512, padded block, word 0 in [511:480].
REQ-010 SHALL have port blk_start, output, 1, one-cycle pulse: blk_data is valid.
REQ-011 SHALL have port blk_finish, input, 1, hash core finished current block.
REQ-012 SHALL have port blk_last, output, 1, the presented block is the final block of the message.
REQ-013 SHALL have port msg_done, output, 1, one-cycle pulse after the final block's blk_finish.

Function
REQ-014 SHALL implement states FILL, PAD, SEND, WAIT, with word index widx 0..15 and message bit counter len.
REQ-015 FILL: in_ready=1; an accepted word is written to word widx; widx++; len += 8*in_bytes.
REQ-016 FILL, accepted non-last word at widx=15 -> SEND.
REQ-017 FILL, accepted last word with in_bytes<4: byte 0x80 is placed immediately after the valid bytes, lower bytes zeroed, widx++, -> PAD.
REQ-018 FILL, accepted last word with in_bytes=4: the word is stored, word widx+1 becomes 0x80000000, -> PAD; if widx=15, 0x80000000 goes into word 0 of the next block.
REQ-019 FILL, in_last with in_bytes=0: no data is stored; the word becomes 0x80000000 (empty tail, empty message).
REQ-020 PAD: writes one zero word per cycle until widx=14, then writes len[63:32] and len[31:0] to words 14 and 15, sets blk_last=1, -> SEND.
REQ-021 PAD: if the 0x80 byte landed at widx>=14, zero-fills to word 15 and goes -> SEND with blk_last=0, and marks an extra block pending; that block is all-zero plus length.
REQ-022 SEND: asserts blk_start for exactly one cycle, -> WAIT.
REQ-023 blk_data and blk_last SHALL remain stable from blk_start until blk_finish.
REQ-024 WAIT: in_ready=0; on blk_finish, if blk_last then pulse msg_done, clear len, -> FILL.
REQ-025 WAIT, on blk_finish with an extra block pending: clear the block, -> PAD at the correct widx.
REQ-026 WAIT, on blk_finish otherwise: widx=0, -> FILL.
REQ-027 blk_finish outside WAIT SHALL be ignored.
REQ-028 in_ready SHALL be 0 in PAD, SEND and WAIT.
REQ-029 At most one word SHALL be accepted per cycle.
REQ-030 len arithmetic SHALL be unsigned and wrap modulo counter width.

Reset
REQ-031 reset low SHALL asynchronously force: state FILL, widx=0, len=0, blk_data=0, blk_start=0, blk_last=0, msg_done=0, in_ready=0, pending cleared.
REQ-032 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-033 Reset mid-message SHALL discard all partial state; no blk_start or msg_done follows.

Configuration
REQ-034 With SHA256_PAD_LEN64_EN defined, len SHALL be a 64-bit counter.
REQ-035 Without SHA256_PAD_LEN64_EN, len SHALL be 32 bits and words 14 (length high) SHALL be written as 0.

Verification
REQ-036 Bench SHALL send 0x61626300, in_bytes=3, last -> one block: 0x61626380, 13 zero words, 0x00000000, 0x00000018; blk_last=1.
REQ-037 Bench SHALL send in_bytes=0, last, only -> block 0x80000000 followed by 15 zero words; msg_done after blk_finish.
REQ-038 Bench SHALL send 14 full words, last -> block 1 data + 0x80000000 in word 14, zeros, blk_last=0; block 2 all zero except word 15=0x000001C0, blk_last=1.
REQ-039 Bench SHALL send 16 full words, last -> block 1 data only; block 2 word 0=0x80000000, word 15=0x00000200.
REQ-040 Bench SHALL hold blk_finish low 100 cycles in WAIT -> in_ready stays 0, blk_data stable, no second blk_start.
REQ-041 Bench SHALL assert reset after 5 words, then send "abc" -> output equals the REQ-036 block.

Source files
------------

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends 0x80, zero fill and bit length.
// Latency: blk_start one cycle after the block's last word is written; backpressure: in_ready low while a block is padded or held.
// Define SHA256_PAD_LEN64_EN for a 64-bit length counter (default 32-bit, length-high word written as 0).
module sha256_padder #(
    parameter int BSWAP = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    output logic [511:0] blk_data,
    output logic         blk_start,
    input  logic         blk_finish,
    output logic         blk_last,
    output logic         msg_done
);

`ifdef SHA256_PAD_LEN64_EN
    localparam int LW = 64;
`else
    localparam int LW = 32;
`endif

    typedef enum logic [1:0] {FILL, PAD, SEND, WAIT} state_t;

    state_t           state_q, state_n;
    logic [15:0][31:0] blk_q;
    logic [3:0]       widx_q;
    logic [LW-1:0]    len_q;
    logic             pend_q;
    logic             pend_m0_q;   // extra block starts with the 0x80000000 marker in word 0
    logic             accept;
    logic             full;
    logic [3:0]       idx_cur, idx_nxt;
    logic [31:0]      din, tail_word, len_hi, len_lo;

    assign accept   = in_valid && in_ready;
    assign full     = (in_bytes >= 3'd4);
    assign idx_cur  = 4'd15 - widx_q;
    assign idx_nxt  = 4'd14 - widx_q;
    assign blk_data = blk_q;
    assign len_lo   = len_q[31:0];
`ifdef SHA256_PAD_LEN64_EN
    assign len_hi   = len_q[63:32];
`else
    assign len_hi   = 32'h0;
`endif

    always_comb begin
        din = in_data;
        if (BSWAP != 0)
            din = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
    end

    always_comb begin
        case (in_bytes)
            3'd0:    tail_word = 32'h8000_0000;
            3'd1:    tail_word = {din[31:24], 24'h80_0000};
            3'd2:    tail_word = {din[31:16], 16'h8000};
            3'd3:    tail_word = {din[31:8], 8'h80};
            default: tail_word = din;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        // marker lands in the last word: nothing left to pad in this block
                        if (full ? (widx_q >= 4'd14) : (widx_q == 4'd15))
                            state_n = SEND;
                        else
                            state_n = PAD;
                    end else if (widx_q == 4'd15) begin
                        state_n = SEND;
                    end
                end
            end
            PAD:     if (widx_q == 4'd15) state_n = SEND;
            SEND:    state_n = WAIT;
            WAIT:    if (blk_finish) state_n = (!blk_last && pend_q) ? PAD : FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            blk_q     <= '0;
            widx_q    <= '0;
            len_q     <= '0;
            pend_q    <= 1'b0;
            pend_m0_q <= 1'b0;
            blk_start <= 1'b0;
            blk_last  <= 1'b0;
            msg_done  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_n;
            in_ready  <= (state_n == FILL);
            blk_start <= (state_n == SEND);
            msg_done  <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        len_q  <= len_q + LW'({in_bytes, 3'b000});
                        widx_q <= widx_q + 4'd1;
                        if (!in_last) begin
                            blk_q[idx_cur] <= din;
                        end else if (!full) begin
                            blk_q[idx_cur] <= tail_word;
                            if (widx_q >= 4'd14) begin
                                pend_q    <= 1'b1;
                                pend_m0_q <= 1'b0;
                            end
                        end else begin
                            blk_q[idx_cur] <= din;
                            if (widx_q == 4'd15) begin
                                pend_q    <= 1'b1;
                                pend_m0_q <= 1'b1;
                            end else begin
                                blk_q[idx_nxt] <= 32'h8000_0000;
                                widx_q         <= widx_q + 4'd2;
                                if (widx_q >= 4'd13) begin
                                    pend_q    <= 1'b1;
                                    pend_m0_q <= 1'b0;
                                end
                            end
                        end
                    end
                end
                PAD: begin
                    widx_q <= widx_q + 4'd1;
                    if (pend_q || widx_q < 4'd14) begin
                        blk_q[idx_cur] <= 32'h0;
                    end else if (widx_q == 4'd14) begin
                        blk_q[idx_cur] <= len_hi;
                    end else begin
                        blk_q[idx_cur] <= len_lo;
                        blk_last       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (blk_finish) begin
                        blk_last <= 1'b0;
                        widx_q   <= 4'd0;
                        if (blk_last) begin
                            msg_done <= 1'b1;
                            len_q    <= '0;
                        end else if (pend_q) begin
                            pend_q <= 1'b0;
                            blk_q  <= '0;
                            if (pend_m0_q) begin
                                blk_q[15] <= 32'h8000_0000;
                                widx_q    <= 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
